pcre_nfa_engine: RTL and testbench
==================================

# pcre_nfa_engine

Parametrised payload-matching NFA: one one-hot flop per pattern state, driven by the shared per-byte character-class decode lines, with sticky match output. Successor of the fixed per-rule engines. It adds:
- a pattern taken entirely from parameters (state classes, self-loops, optional states);
- an anchored mode;
- a Snort-style depth limit;
- a first-match byte offset;
- an end-of-payload result strobe.

One instance per rule sits behind the payload class decoder.

## Interface
Parameters:
- N_CLASS, 128: width of the class-decode bus.
- N_STATES, 40: pattern states, excluding the final/accept flop.
- STATE_CLASS, all 0: N_STATES×8-bit packed; entry i selects the class line tested by state i.
- LOOP, 0: N_STATES-bit mask; state i re-arms itself on its own class (`.*?`, `\s*`).
- OPT, 0: N_STATES-bit mask; state i may be bypassed (zero-occurrence quantifier).
- ANCHORED, 0: 1 = pattern may start only at payload byte 0.
- DEPTH, 0: bytes searched from payload start; 0 = unlimited.
- OFF_W, 16: width of byte counter and offset.

Ports:
- clk  in  1  byte clock
- sod  in  1  start of data: asynchronous, active-high reset; clears all state at every payload start
- en  in  1  a valid payload byte is presented this cycle
- eop  in  1  with en: this byte is the last of the payload
- cls  in  N_CLASS  one-hot-per-class decode of the current byte
- match  out  1  sticky: pattern matched in this payload
- match_off  out  OFF_W  byte index of the byte that completed the first match
- done  out  1  one-cycle strobe after the last byte
- done_match  out  1  copy of match, qualified by done

## Operation
- Byte counter `cnt`: cleared by sod; +1 on each en; saturates at all-ones. `cnt` is the index of the current byte.
- Search window: `act = en & (DEPTH==0 | cnt < DEPTH)`. Outside the window, state flops hold and no new match is taken. The counter and done logic still run.
- Start: `start = ANCHORED ? (cnt==0) : 1`.
- Entry chain (combinational):
  - `e[0] = start`
  - `e[i] = s[i-1] | (OPT[i-1] & e[i-1])`
- Next state: `d[i] = cls[STATE_CLASS[i]] & (e[i] | (LOOP[i] & s[i]))`. On act, `s[i] <= d[i]`.
- Accept: `hit = s[N-1] | (OPT[N-1] & e[N-1])`, taken from the registered state, one byte after completion.
  - Same-cycle form: hit uses d[N-1] instead of s[N-1], gated by act.
  - On hit with match==0: set match, capture match_off = cnt.
  - Match is sticky until sod. Later hits never move match_off.
- eop & en: done and done_match assert on the next cycle for exactly one cycle. Further bytes before sod continue counting and may produce another done.
- sod asserted mid-payload: all flops (states, cnt, match, match_off, done) clear immediately. The byte presented with sod high is ignored.
- Reset values: match=0, match_off=0, done=0, done_match=0.

## Timing
- Single clock; all outputs registered.
- Byte k arrives at edge k. The completing byte k sets match at edge k, visible in cycle k+1, with match_off=k. One cycle better than the chained end-state flop of the older engines.
- done: rises in the cycle after the eop byte's edge. Reflects a match completed by that same eop byte.
- en=0: no state, counter, or output change, except that done deasserts.
- Critical path: the OPT entry chain ripples through consecutive optional states. Patterns are limited to 4 consecutive OPT states; checked by elaboration assertion.

## Structure
- Package pcre_nfa_pkg:
  - named class indices for the shared decoder (e.g. CLS_ANY=109, CLS_SPACE);
  - N_CLASS default;
  - pack helper function for STATE_CLASS.
- Sub-module pcre_nfa_cell: one state (or-of-entries, and-with-class, FDCE-style flop with async clear on sod). Generated N_STATES times.
- Top level holds the entry chain, counter, depth gate, accept/offset logic and done strobe.

## Test plan
Bench instance: pattern /ab.*?c/, N_STATES=4, STATE_CLASS = {a, b, ANY, c}, LOOP=0100 (state 2), OPT=0100.
- "xabzzc", eop on byte 5 -> match rises cycle 6, match_off=5, done=1 and done_match=1 for one cycle.
- "abc" -> the .*? state is bypassed; match_off=2.
- "abcabc" -> match_off stays 2; match stays 1 through byte 5.
- ANCHORED=1, "xabc" -> match stays 0; done with done_match=0. "abc" -> match_off=2.
- DEPTH=4, "zzabzc" -> no match; DEPTH=6 -> match_off=5.
- sod pulsed after "ab", then "c" -> match stays 0. Outputs read 0 immediately after sod, with no clock edge.

Source files
------------

// File: rtl/pcre_nfa_pkg.sv
// Shared definitions for the payload NFA engines: class-decoder line indices
// and helpers for building pattern parameters.
package pcre_nfa_pkg;

    localparam int N_CLASS_DEF = 128;

    // Printable ASCII literals occupy lines 0..95 (byte - 0x20); classes follow.
    localparam int CLS_LIT_BASE = 0;
    localparam int CLS_ANY      = 109;
    localparam int CLS_SPACE    = 110;
    localparam int CLS_DIGIT    = 111;
    localparam int CLS_WORD     = 112;

    function automatic logic [7:0] cls_lit(logic [7:0] ch);
        return ch - 8'h20 + 8'(CLS_LIT_BASE);
    endfunction

    // Entry i of the result lands at bits [i*8 +: 8].
    function automatic logic [31:0] pack4(logic [7:0] c0, logic [7:0] c1,
                                          logic [7:0] c2, logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic int max_run(logic [255:0] m, int n);
        int run;
        int best;
        run  = 0;
        best = 0;
        for (int i = 0; i < n; i++) begin
            run = m[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

endpackage

// File: rtl/pcre_nfa_engine_if.sv
// Byte stream in, match result out, between the class decoder and one rule engine.
interface pcre_nfa_engine_if #(
    parameter int N_CLASS = 128,
    parameter int OFF_W   = 16
);
    logic               en;
    logic               eop;
    logic [N_CLASS-1:0] cls;
    logic               match;
    logic [OFF_W-1:0]   match_off;
    logic               done;
    logic               done_match;

    modport master (output en, eop, cls, input match, match_off, done, done_match);
    modport slave  (input en, eop, cls, output match, match_off, done, done_match);
endinterface

// File: rtl/pcre_nfa_cell.sv
// One NFA state: armed by its entry or its own self-loop, qualified by its class line.
module pcre_nfa_cell #(
    parameter logic LOOP = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic act,
    input  logic cls_hit,
    input  logic entry,
    output logic s,
    output logic d
);

    assign d = cls_hit & (entry | (LOOP & s));

    always_ff @(posedge clk or posedge clr) begin
        if (clr)      s <= 1'b0;
        else if (act) s <= d;
    end

endmodule

// File: rtl/pcre_nfa_engine.sv
// Parametrised one-hot NFA payload matcher with depth limit, anchoring,
// sticky first-match offset and end-of-payload result strobe.
module pcre_nfa_engine
    import pcre_nfa_pkg::*;
#(
    parameter int                      N_CLASS     = N_CLASS_DEF,
    parameter int                      N_STATES    = 40,
    parameter logic [N_STATES*8-1:0]   STATE_CLASS = '0,
    parameter logic [N_STATES-1:0]     LOOP        = '0,
    parameter logic [N_STATES-1:0]     OPT         = '0,
    parameter logic                    ANCHORED    = 1'b0,
    parameter int                      DEPTH       = 0,
    parameter int                      OFF_W       = 16
) (
    input logic              clk,
    input logic              sod,
    pcre_nfa_engine_if.slave bus
);

    if (N_STATES < 1 || N_STATES > 256) begin : g_nstates_chk
        $error("pcre_nfa_engine: N_STATES must be 1..256");
    end
    if (OFF_W < 1 || OFF_W > 32) begin : g_offw_chk
        $error("pcre_nfa_engine: OFF_W must be 1..32");
    end
    // The OPT bypass ripples combinationally; long runs break timing.
    if (max_run(256'(OPT), N_STATES) > 4) begin : g_opt_chk
        $error("pcre_nfa_engine: more than 4 consecutive optional states");
    end

    logic [OFF_W-1:0]    cnt;
    logic                act;
    logic                start;
    logic                hit;
    logic [N_STATES-1:0] s;
    logic [N_STATES-1:0] d;
    logic [N_STATES-1:0] e;
    logic                unused_cls;

    assign unused_cls = ^bus.cls;

    assign act   = bus.en & ((DEPTH == 0) || (33'(cnt) < 33'(DEPTH)));
    assign start = ANCHORED ? (cnt == '0) : 1'b1;

    always_comb begin
        e    = '0;
        e[0] = start;
        for (int i = 1; i < N_STATES; i++)
            e[i] = s[i-1] | (OPT[i-1] & e[i-1]);
    end

    for (genvar i = 0; i < N_STATES; i++) begin : g_state
        localparam int CI = int'(STATE_CLASS[i*8 +: 8]);
        if (CI >= N_CLASS) begin : g_cls_chk
            $error("pcre_nfa_engine: STATE_CLASS entry out of range");
        end
        pcre_nfa_cell #(.LOOP(LOOP[i])) u_cell (
            .clk     (clk),
            .clr     (sod),
            .act     (act),
            .cls_hit (bus.cls[CI]),
            .entry   (e[i]),
            .s       (s[i]),
            .d       (d[i])
        );
    end

    // Accept on the completing byte itself rather than on the next one.
    assign hit = act & (d[N_STATES-1] | (OPT[N_STATES-1] & e[N_STATES-1]));

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            cnt            <= '0;
            bus.match      <= 1'b0;
            bus.match_off  <= '0;
            bus.done       <= 1'b0;
            bus.done_match <= 1'b0;
        end else begin
            if (bus.en && cnt != '1) cnt <= cnt + 1'b1;
            if (hit && !bus.match) begin
                bus.match     <= 1'b1;
                bus.match_off <= cnt;
            end
            bus.done       <= bus.en & bus.eop;
            bus.done_match <= bus.en & bus.eop & (bus.match | hit);
        end
    end

endmodule

// File: tb/tb_pcre_nfa_engine.sv
// Directed bench for /ab.*?c/ across unanchored, anchored and depth-limited instances.
module tb_pcre_nfa_engine;
    import pcre_nfa_pkg::*;

    localparam int               NC = 128;
    localparam int               OW = 16;
    localparam logic [31:0]      SC = pack4(cls_lit(8'h61), cls_lit(8'h62),
                                            8'(CLS_ANY), cls_lit(8'h63));

    logic          clk = 1'b0;
    logic          sod = 1'b1;
    logic          en  = 1'b0;
    logic          eop = 1'b0;
    logic [NC-1:0] cls = '0;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    always #5 clk = ~clk;

    pcre_nfa_engine_if #(.N_CLASS(NC), .OFF_W(OW)) if0 ();
    pcre_nfa_engine_if #(.N_CLASS(NC), .OFF_W(OW)) if1 ();
    pcre_nfa_engine_if #(.N_CLASS(NC), .OFF_W(OW)) if2 ();
    pcre_nfa_engine_if #(.N_CLASS(NC), .OFF_W(OW)) if3 ();

    assign if0.en = en;  assign if0.eop = eop;  assign if0.cls = cls;
    assign if1.en = en;  assign if1.eop = eop;  assign if1.cls = cls;
    assign if2.en = en;  assign if2.eop = eop;  assign if2.cls = cls;
    assign if3.en = en;  assign if3.eop = eop;  assign if3.cls = cls;

    pcre_nfa_engine #(.N_CLASS(NC), .N_STATES(4), .STATE_CLASS(SC), .LOOP(4'b0100),
                      .OPT(4'b0100), .ANCHORED(1'b0), .DEPTH(0), .OFF_W(OW))
        u_free (.clk(clk), .sod(sod), .bus(if0.slave));
    pcre_nfa_engine #(.N_CLASS(NC), .N_STATES(4), .STATE_CLASS(SC), .LOOP(4'b0100),
                      .OPT(4'b0100), .ANCHORED(1'b1), .DEPTH(0), .OFF_W(OW))
        u_anch (.clk(clk), .sod(sod), .bus(if1.slave));
    pcre_nfa_engine #(.N_CLASS(NC), .N_STATES(4), .STATE_CLASS(SC), .LOOP(4'b0100),
                      .OPT(4'b0100), .ANCHORED(1'b0), .DEPTH(4), .OFF_W(OW))
        u_dep4 (.clk(clk), .sod(sod), .bus(if2.slave));
    pcre_nfa_engine #(.N_CLASS(NC), .N_STATES(4), .STATE_CLASS(SC), .LOOP(4'b0100),
                      .OPT(4'b0100), .ANCHORED(1'b0), .DEPTH(6), .OFF_W(OW))
        u_dep6 (.clk(clk), .sod(sod), .bus(if3.slave));

    function automatic logic [NC-1:0] make_cls(logic [7:0] ch);
        logic [NC-1:0] v;
        v = '0;
        v[7'(cls_lit(ch))] = 1'b1;
        v[CLS_ANY] = 1'b1;
        if (ch == 8'h20) v[CLS_SPACE] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] ch, input logic last);
        en  = 1'b1;
        eop = last;
        cls = make_cls(ch);
        @(posedge clk);
        #1;
        en  = 1'b0;
        eop = 1'b0;
        cls = '0;
    endtask

    task automatic send_str(input string str, input logic last_eop);
        for (int i = 0; i < str.len(); i++)
            send(str[i], last_eop && (i == str.len() - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sod;
        sod = 1'b1;
        #1;
        sod = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_match", 32'(if0.match), 32'd0);
        chk("rst_off", 32'(if0.match_off), 32'd0);
        chk("rst_done", 32'(if0.done), 32'd0);
        chk("rst_done_match", 32'(if0.done_match), 32'd0);
        sod = 1'b0;
        idle(1);

        // "xabzzc": completion on byte 5
        send_str("xabzz", 1'b0);
        chk("a_match_early", 32'(if0.match), 32'd0);
        send(8'h63, 1'b1);
        chk("a_match", 32'(if0.match), 32'd1);
        chk("a_off", 32'(if0.match_off), 32'd5);
        chk("a_done", 32'(if0.done), 32'd1);
        chk("a_done_match", 32'(if0.done_match), 32'd1);
        chk("a_anch_match", 32'(if1.match), 32'd0);
        chk("a_anch_done", 32'(if1.done), 32'd1);
        chk("a_anch_done_match", 32'(if1.done_match), 32'd0);
        chk("a_dep4_match", 32'(if2.match), 32'd0);
        chk("a_dep6_off", 32'(if3.match_off), 32'd5);
        idle(1);
        chk("a_done_fall", 32'(if0.done), 32'd0);
        chk("a_done_match_fall", 32'(if0.done_match), 32'd0);
        chk("a_match_sticky", 32'(if0.match), 32'd1);

        // "abcabc": bypass of .*?, first offset kept
        pulse_sod;
        send_str("abc", 1'b0);
        chk("b_match", 32'(if0.match), 32'd1);
        chk("b_off", 32'(if0.match_off), 32'd2);
        chk("b_anch_off", 32'(if1.match_off), 32'd2);
        chk("b_anch_match", 32'(if1.match), 32'd1);
        send_str("abc", 1'b1);
        chk("b_off_kept", 32'(if0.match_off), 32'd2);
        chk("b_match_kept", 32'(if0.match), 32'd1);
        chk("b_done_match", 32'(if0.done_match), 32'd1);

        // "zzabzc": depth window 4 vs 6
        pulse_sod;
        send_str("zzabzc", 1'b1);
        chk("c_dep4_match", 32'(if2.match), 32'd0);
        chk("c_dep4_done", 32'(if2.done), 32'd1);
        chk("c_dep4_done_match", 32'(if2.done_match), 32'd0);
        chk("c_dep6_match", 32'(if3.match), 32'd1);
        chk("c_dep6_off", 32'(if3.match_off), 32'd5);
        chk("c_anch_match", 32'(if1.match), 32'd0);

        // asynchronous clear mid-cycle
        pulse_sod;
        send_str("abc", 1'b1);
        chk("d_pre_match", 32'(if0.match), 32'd1);
        chk("d_pre_done", 32'(if0.done), 32'd1);
        sod = 1'b1;
        #1;
        chk("d_sod_match", 32'(if0.match), 32'd0);
        chk("d_sod_off", 32'(if0.match_off), 32'd0);
        chk("d_sod_done", 32'(if0.done), 32'd0);
        chk("d_sod_done_match", 32'(if0.done_match), 32'd0);
        sod = 1'b0;

        // sod between "ab" and "c" kills the partial match
        send_str("ab", 1'b0);
        pulse_sod;
        send(8'h63, 1'b1);
        chk("e_match", 32'(if0.match), 32'd0);
        chk("e_done", 32'(if0.done), 32'd1);
        chk("e_done_match", 32'(if0.done_match), 32'd0);

        // en=0 gaps neither advance the counter nor disturb the states
        pulse_sod;
        send_str("ab", 1'b0);
        idle(2);
        send(8'h63, 1'b1);
        chk("f_match", 32'(if0.match), 32'd1);
        chk("f_off", 32'(if0.match_off), 32'd2);
        chk("f_anch_off", 32'(if1.match_off), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
